// File: rtl/i2s_rx.sv
// I2S slave receiver: synchronises an external sclk/lrclk/sdata bus, reassembles
// Philips-framed left/right words and strobes each completed stereo pair.
// Optional length checking is enabled by defining I2S_RX_FRAME_CHECK_EN.
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             lrclk,
  input  logic             sdata,
  output logic [WIDTH-1:0] left_chan,
  output logic [WIDTH-1:0] right_chan,
  output logic             valid,
  output logic             frame_err
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  logic sclk_meta_q, sclk_sync_q, sclk_hist_q;
  logic lr_meta_q, lr_sync_q;
  logic sd_meta_q, sd_sync_q;

  // NOTE: synchroniser flops carry no reset so they keep tracking the bus while
  // rst is held, letting lr_prev load a settled lrclk on the first free cycle.
  always_ff @(posedge clk) begin
    sclk_meta_q <= sclk;
    sclk_sync_q <= sclk_meta_q;
    sclk_hist_q <= sclk_sync_q;
    lr_meta_q   <= lrclk;
    lr_sync_q   <= lr_meta_q;
    sd_meta_q   <= sdata;
    sd_sync_q   <= sd_meta_q;
  end

  state_t           state_q, state_d;
  logic             init_q, init_d;
  logic             lr_prev_q, lr_prev_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] left_hold_q, left_hold_d;
  logic             have_left_q, have_left_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic [WIDTH-1:0] right_q, right_d;
  logic             valid_q, valid_d;
`ifdef I2S_RX_FRAME_CHECK_EN
  logic             over_q, over_d;
  logic             frame_err_q, frame_err_d;
`endif

  logic             rise;
  logic             lr_edge;
  logic             saturated;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] word;

  assign rise      = sclk_sync_q & ~sclk_hist_q;
  assign lr_edge   = lr_sync_q ^ lr_prev_q;
  assign saturated = (cnt_q == CNT_FULL);
  // Shifting the MSB marker right by cnt gives an empty mask once saturated,
  // so extra bits fall away without a separate compare.
  assign bit_mask  = MSB_BIT >> cnt_q;
  assign word      = shift_q | ({WIDTH{sd_sync_q}} & bit_mask);

  // NOTE: every _d starts from its _q so no path through this block leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    lr_prev_d   = lr_prev_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    have_left_d = have_left_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
    over_d      = over_q;
    frame_err_d = 1'b0;
`endif

    if (init_q) begin
      init_d    = 1'b0;
      lr_prev_d = lr_sync_q;
    end else if (rise) begin
      lr_prev_d = lr_sync_q;
      if (!lr_edge) begin
        if (state_q == SYNC) begin
          shift_d = word;
          if (!saturated) cnt_d = cnt_q + CW'(1);
`ifdef I2S_RX_FRAME_CHECK_EN
          over_d = over_q | saturated;
`endif
        end
      end else begin
        if (state_q == UNSYNC) begin
          state_d     = SYNC;
          have_left_d = 1'b0;
        end else begin
          if (!lr_prev_q) begin
            left_hold_d = word;
            have_left_d = 1'b1;
          end else if (have_left_q) begin
            left_d      = left_hold_q;
            right_d     = word;
            valid_d     = 1'b1;
            have_left_d = 1'b0;
          end
`ifdef I2S_RX_FRAME_CHECK_EN
          // Short when fewer than WIDTH-1 bits preceded the completing bit;
          // long when the counter was already full as further bits arrived.
          frame_err_d = (cnt_q < CNT_LAST) | saturated | over_q;
`endif
        end
        shift_d = '0;
        cnt_d   = '0;
`ifdef I2S_RX_FRAME_CHECK_EN
        over_d  = 1'b0;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSYNC;
      init_q      <= 1'b1;
      lr_prev_q   <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      have_left_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
      over_q      <= 1'b0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      lr_prev_q   <= lr_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      have_left_q <= have_left_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
`ifdef I2S_RX_FRAME_CHECK_EN
      over_q      <= over_d;
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;
`ifdef I2S_RX_FRAME_CHECK_EN
  assign frame_err  = frame_err_q;
`else
  assign frame_err  = 1'b0;
`endif

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S slave receiver, the receive-side counterpart of `i2s_tx`. It samples an externally driven I2S bus (`sclk`, `lrclk`, `sdata`) and reassembles left/right PCM words. It presents each completed stereo pair on parallel outputs with a one-cycle strobe. It sits in the audio path next to `i2s_tx` on the `clk_114` domain and feeds line-in or codec ADC samples into the core.

## Interface
Parameters:
- `WIDTH`, 16: bits per channel word, MSB first.

Ports:
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: I2S bit clock, asynchronous to `clk`.
- `lrclk` in 1: I2S word select; 0 = left, 1 = right. Asynchronous.
- `sdata` in 1: I2S serial data. Asynchronous.
- `left_chan` out `WIDTH`: left sample of the last completed pair.
- `right_chan` out `WIDTH`: right sample of the last completed pair.
- `valid` out 1: one-cycle pulse; `left_chan`/`right_chan` updated this cycle.
- `frame_err` out 1: one-cycle pulse on a malformed word (see Configuration).

## Operation
- **Input synchronisation.** `sclk`, `lrclk` and `sdata` each pass through a 2-flop synchroniser, then one history flop on `sclk`.
- **Edge detection.** A bit event (`rise`) is synchronised `sclk` = 1 while its history flop = 0. Only `rise` advances state; falling `sclk` is ignored.
- **Per `rise`.** Sample `sd` (synchronised `sdata`) and `lr` (synchronised `lrclk`). Compare `lr` with `lr_prev`, the `lr` from the previous `rise`.
- **Philips framing.** The bit sampled on the first `rise` with `lr != lr_prev` is the LSB of the word for channel `lr_prev`. The MSB of the new word arrives on the next `rise`.
- **Shift register.** Bit index `cnt` counts 0..`WIDTH`, saturating at `WIDTH`. While `cnt < WIDTH`, `sd` is written to bit `WIDTH-1-cnt` and `cnt` increments. Bits beyond `WIDTH` are dropped. Unreceived LSBs stay 0, so short words are MSB-justified and zero-padded.
- **Word completion.** A word completes on a `rise` with `lr != lr_prev`. The completing bit is included, so `nbits` = `cnt`+1 saturated at `WIDTH`, counting the completing bit only if `cnt < WIDTH`.
  - If `lr_prev` = 0, the word goes to an internal `left_hold`.
  - If `lr_prev` = 1, `left_chan` ← `left_hold`, `right_chan` ← the word, and `valid` pulses.
  - After either case, the shift register is cleared and `cnt` ← 0.
- **States:**
  - `UNSYNC` (reset state): shift data is ignored. The first `rise` with `lr != lr_prev` moves to `SYNC` and discards the partial word. No `valid` or `frame_err` is produced.
  - `SYNC`: normal reception as above.
- **Pairing.** `valid` is only raised if a left word has completed since the last `valid` (or since entering `SYNC`). A right word with no preceding left word is discarded.
- **Reset** (any time, including mid-word):
  - State returns to `UNSYNC`; `cnt` = 0.
  - Shift register, `left_hold`, `left_chan` and `right_chan` = 0.
  - `valid` = 0, `frame_err` = 0.
  - `lr_prev` loads the synchronised `lrclk` on the first cycle after reset.

## Timing
- A pin-level `sclk` rising edge meeting setup at clk edge N shows as `rise` in the cycle after edge N+1. State and outputs are registered at edge N+2.
- `valid` and `frame_err` are high for exactly one `clk` cycle. `left_chan`/`right_chan` are stable from the `valid` edge until the next `valid`.
- Input requirements: `sclk` high and low each ≥ 3 `clk` periods. `lrclk` and `sdata` change only on falling `sclk` and are stable at rising `sclk`.
- Operating point: `clk` = 114 MHz, `sclk` up to ~12 MHz.
- Stereo frame rate: one `valid` per `lrclk` period, 2×`nbits` `rise` events per frame for a well-formed stream.

## Configuration
- Macro `I2S_RX_FRAME_CHECK_EN`.
- **Defined:** in `SYNC`, on every word completion with `nbits != WIDTH`, `frame_err` pulses in the same cycle the word is stored. "Too many bits" is detected by `cnt` having saturated and at least one further bit received; the counter for this is internal and one bit wide. The word is still stored and `valid` still follows the normal rules.
- **Undefined:** `frame_err` is tied to 0 and the over-length tracking logic is removed. Reception is otherwise identical.

## Test plan
- **Reset values:** assert `rst` 2 cycles with the bus idle → `left_chan` = 0, `right_chan` = 0, `valid` = 0, `frame_err` = 0; no `valid` until one full L+R pair follows the first `lrclk` edge.
- **Nominal stream:** `WIDTH`=16, clk 114 MHz, sclk 3.072 MHz, send L=16'hA55A, R=16'h0F0F repeatedly → first `valid` after the second complete frame, with `left_chan`=A55A and `right_chan`=0F0F; one `valid` per frame; `frame_err` never set.
- **Short word:** send a left word of 12 bits 12'hABC → `left_chan`=16'hABC0 at the next `valid`; `frame_err` pulses once with the macro defined, stays 0 without it.
- **Long word:** send a right word of 18 bits, first 16 = 16'h1234 → `right_chan`=1234; `frame_err` pulses once with the macro defined.
- **Reset mid-word:** `rst` after 8 bits of a left word → outputs clear to 0; the next `valid` carries only the pair from the first full frame after resync, never the truncated word.
- **Unpaired right:** right word arriving immediately after entering `SYNC` with no preceding left → no `valid`; the following L=16'h0001, R=16'h0002 produces `valid` with those values.
